// File: rtl/bus_arb_pkg.sv
// Shared types and constants for the bus round-robin arbiter.
package bus_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        POP  = 2'd1,
        XFER = 2'd2
    } state_t;

    localparam int         ID_W_DEF  = 8;
    localparam logic [7:0] BCAST_DEF = 8'hFF;

    // Extracts the destination-ID field (top id_w bits) of a packet that is
    // width bits wide. The packet is passed zero-extended to 64 bits, so
    // packets up to 64 bits wide are handled.
    function automatic logic [31:0] dest_of(input logic [63:0] pkt,
                                            input int          width,
                                            input int          id_w);
        logic [63:0] shifted;
        logic [63:0] mask;
        shifted = pkt >> (width - id_w);
        mask    = (64'd1 << id_w) - 64'd1;
        return 32'(shifted & mask);
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: finds the first set request strictly
// after `last`, wrapping around, using a doubled request vector and a window
// mask followed by a lowest-bit priority search.
module rr_picker #(
    parameter  int N  = 8,
    localparam int LW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [LW-1:0] last,
    output logic [LW-1:0] gnt_idx,
    output logic          gnt_valid
);

    localparam int IW = $clog2(2 * N) + 1;

    logic [2*N-1:0] dbl;
    logic [2*N-1:0] masked;
    logic [IW-1:0]  last_ext;
    logic [IW-1:0]  hit_pos;

    assign dbl      = {req, req};
    assign last_ext = IW'(last);

    // Keep only the N positions last+1 .. last+N of the doubled vector.
    generate
        for (genvar gi = 0; gi < 2 * N; gi++) begin : g_mask
            assign masked[gi] = dbl[gi]
                              && (IW'(gi) > last_ext)
                              && (IW'(gi) <= last_ext + IW'(N));
        end
    endgenerate

    // Lowest set bit inside the window is the next source in rotation.
    always_comb begin
        hit_pos   = '0;
        gnt_valid = 1'b0;
        for (int j = 2 * N - 1; j >= 0; j--) begin
            if (masked[j]) begin
                hit_pos   = IW'(j);
                gnt_valid = 1'b1;
            end
        end
    end

    // Fold the doubled position back onto a source index.
    assign gnt_idx = (hit_pos >= IW'(N)) ? LW'(hit_pos - IW'(N)) : LW'(hit_pos);

endmodule

// File: rtl/bus_rr_arbiter.sv
// Round-robin bus arbiter and packet forwarder: grants one pending driver
// FIFO, pops one word from it and pushes that word to the addressed FIFO
// (or to every other FIFO on broadcast). One packet per three cycles.
module bus_rr_arbiter
    import bus_arb_pkg::*;
#(
    parameter  int              width = 16,
    parameter  int              DRVS  = 8,
    parameter  int              ID_W  = ID_W_DEF,
    parameter  logic [ID_W-1:0] BCAST = ID_W'(BCAST_DEF),
    localparam int              GW    = $clog2(DRVS)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [DRVS-1:0]         pndng,
    input  logic [DRVS*width-1:0]   D_pop,
    output logic [DRVS-1:0]         pop,
    output logic [DRVS-1:0]         push,
    output logic [DRVS*width-1:0]   D_push,
    output logic                    busy,
    output logic [GW-1:0]           grant_id,
    output logic [7:0]              drop_cnt
);

    state_t          state;
    logic [GW-1:0]   last_grant;
    logic [GW-1:0]   pick_idx;
    logic            pick_valid;
    logic [width-1:0] pkt;
    logic [width-1:0] head;
    logic [width-1:0] lane [DRVS];
    logic [ID_W-1:0] dest;
    logic            dest_bcast;
    logic            drop_hit;
    logic [DRVS-1:0] pick_oh;
    logic [DRVS-1:0] grant_oh;
    logic [DRVS-1:0] push_dec;

    rr_picker #(.N(DRVS)) u_picker (
        .req       (pndng),
        .last      (last_grant),
        .gnt_idx   (pick_idx),
        .gnt_valid (pick_valid)
    );

    // Per-lane views of the flat buses plus one-hot and push decode.
    // An unrecognised destination matches no lane, leaving push_dec zero.
    generate
        for (genvar gi = 0; gi < DRVS; gi++) begin : g_lane
            assign lane[gi]                     = D_pop[gi*width +: width];
            assign D_push[gi*width +: width]    = pkt;
            assign pick_oh[gi]                  = (pick_idx == GW'(gi));
            assign grant_oh[gi]                 = (grant_id == GW'(gi));
            assign push_dec[gi]                 = dest_bcast ? !grant_oh[gi]
                                                             : (dest == ID_W'(gi));
        end
    endgenerate

    // During POP grant_id already names the granted source, so head is its
    // FIFO word; the push pattern is decoded from it ahead of the XFER cycle.
    assign head       = lane[grant_id];
    assign dest       = ID_W'(dest_of(64'(head), width, ID_W));
    assign dest_bcast = (dest == BCAST);
    assign drop_hit   = !dest_bcast && !(|push_dec);

    // Arbitration FSM; every output is a register updated here.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            pop        <= '0;
            push       <= '0;
            pkt        <= '0;
            busy       <= 1'b0;
            drop_cnt   <= 8'd0;
            grant_id   <= '0;
            last_grant <= GW'(DRVS - 1);
        end else begin
            pop  <= '0;
            push <= '0;
            unique case (state)
                IDLE: begin
                    if (pick_valid) begin
                        state      <= POP;
                        busy       <= 1'b1;
                        last_grant <= pick_idx;
                        grant_id   <= pick_idx;
                        pop        <= pick_oh;
                    end
                end
                POP: begin
                    state <= XFER;
                    pkt   <= head;
                    push  <= push_dec;
                    if (drop_hit && drop_cnt != 8'hFF) begin
                        drop_cnt <= drop_cnt + 8'd1;
                    end
                end
                XFER: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Self-checking bench for bus_rr_arbiter: bench-side source FIFOs, a
// transaction-level schedule of expected outputs, a per-cycle compare
// process, and directed literal checks.
module tb_bus_rr_arbiter;

    localparam int W    = 16;
    localparam int N    = 8;
    localparam int MAXC = 4000;

    logic           clk   = 1'b0;
    logic           reset = 1'b0;
    logic [N-1:0]   pndng = '0;
    logic [N*W-1:0] d_pop_bus = '0;
    logic [N-1:0]   pop;
    logic [N-1:0]   push;
    logic [N*W-1:0] d_push_bus;
    logic           busy;
    logic [2:0]     grant_id;
    logic [7:0]     drop_cnt;

    bus_rr_arbiter #(.width(W), .DRVS(N)) dut (
        .clk      (clk),
        .reset    (reset),
        .pndng    (pndng),
        .D_pop    (d_pop_bus),
        .pop      (pop),
        .push     (push),
        .D_push   (d_push_bus),
        .busy     (busy),
        .grant_id (grant_id),
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    // Expected outputs per cycle
    logic [N-1:0] exp_pop  [MAXC];
    logic [N-1:0] exp_push [MAXC];
    logic         exp_busy [MAXC];
    logic         exp_x    [MAXC];
    logic [W-1:0] exp_word [MAXC];
    logic [2:0]   exp_gid  [MAXC];
    logic [7:0]   exp_drop [MAXC];

    // Model state
    int m_last, m_free, m_drop, rm_src, rm_cycle;
    bit rnd_on = 1'b0;

    logic [W-1:0] fq [N][$];

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, req);
        end
    endtask

    task automatic model_reset(input int from);
        for (int c = from; c < MAXC; c++) begin
            exp_pop[c]  = '0;
            exp_push[c] = '0;
            exp_busy[c] = 1'b0;
            exp_x[c]    = 1'b0;
            exp_word[c] = '0;
            exp_gid[c]  = '0;
            exp_drop[c] = '0;
        end
        m_last   = N - 1;
        m_free   = 0;
        m_drop   = 0;
        rm_cycle = -1;
    endtask

    // Decide the grant at rising edge e from the bench's own pending set.
    task automatic arbitrate(input int e);
        int           g;
        logic [W-1:0] w;
        logic [7:0]   dest;
        if (e < m_free || e + 1 >= MAXC || pndng == '0) return;
        g = -1;
        for (int i = 1; i <= N; i++) begin
            if (g < 0 && pndng[(m_last + i) % N]) g = (m_last + i) % N;
        end
        w      = fq[g][0];
        dest   = w[15:8];
        m_last = g;
        m_free = e + 3;
        exp_pop[e]    = N'(1) << g;
        exp_busy[e]   = 1'b1;
        exp_busy[e+1] = 1'b1;
        exp_x[e+1]    = 1'b1;
        exp_word[e+1] = w;
        if (dest == 8'hFF)  exp_push[e+1] = ~(N'(1) << g);
        else if (dest < N)  exp_push[e+1] = N'(1) << dest;
        else if (m_drop < 255) m_drop++;
        for (int c = e; c < MAXC; c++)     exp_gid[c]  = 3'(g);
        for (int c = e + 1; c < MAXC; c++) exp_drop[c] = 8'(m_drop);
        rm_src   = g;
        rm_cycle = e + 1;
    endtask

    function automatic logic [W-1:0] rand_word();
        logic [7:0] d;
        case ($urandom_range(0, 3))
            0, 1:    d = 8'($urandom_range(0, N - 1));
            2:       d = 8'hFF;
            default: d = 8'($urandom_range(N, 254));
        endcase
        return {d, 8'($urandom)};
    endfunction

    task automatic drive_inputs();
        for (int i = 0; i < N; i++) begin
            pndng[i] = (fq[i].size() > 0);
            d_pop_bus[i*W +: W] = (fq[i].size() > 0) ? fq[i][0] : W'($urandom);
        end
    endtask

    task automatic step();
        logic [W-1:0] tmp;
        int           s;
        @(negedge clk);
        if (rm_cycle == cyc) begin
            tmp      = fq[rm_src].pop_front();
            rm_cycle = -1;
        end
        if (rnd_on && $urandom_range(0, 2) == 0) begin
            s = $urandom_range(0, N - 1);
            if (fq[s].size() < 4) fq[s].push_back(rand_word());
        end
        drive_inputs();
        if (reset) arbitrate(cyc + 1);
    endtask

    function automatic bit any_queued();
        for (int i = 0; i < N; i++) if (fq[i].size() > 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic drain();
        int t = 0;
        while ((any_queued() || cyc + 1 < m_free) && t < 3000) begin
            step();
            t++;
        end
        chk("drain_bound", 64'(t < 3000), 64'(1));
    endtask

    task automatic send_one(input int src, input logic [W-1:0] w, input logic [N-1:0] lit_pop,
                            input logic [N-1:0] lit_push, input logic [2:0] lit_gid);
        drain();
        fq[src].push_back(w);
        step();
        step();
        chk("lit_pop", 64'(pop), 64'(lit_pop));
        chk("lit_gid", 64'(grant_id), 64'(lit_gid));
        step();
        chk("lit_push", 64'(push), 64'(lit_push));
        chk("lit_dpush_lane0", 64'(d_push_bus[W-1:0]), 64'(w));
        chk("lit_dpush_lane7", 64'(d_push_bus[N*W-1 -: W]), 64'(w));
    endtask

    // Per-cycle comparison against the model schedule
    always @(negedge clk) begin
        if (cyc < MAXC) begin
            chk("pop", 64'(pop), 64'(exp_pop[cyc]));
            chk("push", 64'(push), 64'(exp_push[cyc]));
            chk("busy", 64'(busy), 64'(exp_busy[cyc]));
            chk("grant_id", 64'(grant_id), 64'(exp_gid[cyc]));
            chk("drop_cnt", 64'(drop_cnt), 64'(exp_drop[cyc]));
            if (exp_x[cyc]) begin
                for (int i = 0; i < N; i++)
                    chk("d_push_lane", 64'(d_push_bus[i*W +: W]), 64'(exp_word[cyc]));
            end
        end
    end

    int ord[$];
    int ord_cyc[$];
    int exp_ord[9] = '{0, 1, 2, 3, 4, 5, 6, 7, 0};

    initial begin
        model_reset(0);
        repeat (3) @(negedge clk);
        chk("rst_pop", 64'(pop), 64'(0));
        chk("rst_push", 64'(push), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_gid", 64'(grant_id), 64'(0));
        chk("rst_drop", 64'(drop_cnt), 64'(0));
        chk("rst_dpush", 64'(d_push_bus[W-1:0]), 64'(0));

        // Fairness: every source loaded with two packets before release
        for (int i = 0; i < N; i++) begin
            fq[i].push_back({8'((i + 3) % N), 8'(i)});
            fq[i].push_back({8'(i), 8'hC0});
        end
        reset = 1'b1;
        drive_inputs();
        arbitrate(cyc + 1);
        for (int k = 0; k < 30; k++) begin
            step();
            for (int i = 0; i < N; i++) begin
                if (pop[i]) begin
                    ord.push_back(i);
                    ord_cyc.push_back(cyc);
                end
            end
        end
        chk("rr_count", 64'(ord.size() >= 9), 64'(1));
        for (int k = 0; k < 9 && k < ord.size(); k++)
            chk("rr_order", 64'(ord[k]), 64'(exp_ord[k]));
        for (int k = 1; k < 9 && k < ord.size(); k++)
            chk("rr_spacing", 64'(ord_cyc[k] - ord_cyc[k-1]), 64'(3));
        drain();

        // Directed packets
        send_one(2, 16'h05AB, 8'h04, 8'h20, 3'd2);
        send_one(5, 16'h0577, 8'h20, 8'h20, 3'd5);
        send_one(3, 16'hFF12, 8'h08, 8'hF7, 3'd3);
        chk("lit_drop0", 64'(drop_cnt), 64'(0));
        send_one(1, 16'h0A00, 8'h02, 8'h00, 3'd1);
        chk("lit_drop1", 64'(drop_cnt), 64'(1));

        // Reset during POP aborts the packet
        drain();
        fq[7].push_back(16'h0311);
        step();
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset(cyc);
        #1;
        chk("midrst_pop", 64'(pop), 64'(0));
        chk("midrst_push", 64'(push), 64'(0));
        chk("midrst_busy", 64'(busy), 64'(0));
        step();
        step();
        reset = 1'b1;
        drive_inputs();
        arbitrate(cyc + 1);
        step();
        chk("midrst_first_pop", 64'(pop), 64'(8'h80));
        drain();

        // Random traffic
        rnd_on = 1'b1;
        for (int k = 0; k < 600; k++) step();
        rnd_on = 1'b0;
        drain();

        // Drop counter saturation
        for (int k = 0; k < 300; k++) fq[1].push_back(16'h0A00);
        drain();
        chk("lit_drop_sat", 64'(drop_cnt), 64'(255));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/bus_rr_arbiter.md
# bus_rr_arbiter

Round-robin arbiter and packet forwarder for the shared bus between `DRVS` driver FIFOs. It grants one pending source at a time, pops one word from that source, and pushes the word to the destination FIFO named in its header, or to all other FIFOs on broadcast. It sits between the per-driver FIFO interfaces (`pndng`/`pop`/`D_pop` in, `push`/`D_push` out) and is the sequencing core of the bus.

## Interface
- `width`, 16: packet width in bits; must be > `ID_W`.
- `DRVS`, 8: number of drivers; 2..255.
- `ID_W`, 8: destination-ID field width, occupying packet bits [`width-1` : `width-ID_W`].
- `BCAST`, 8'hFF: destination ID meaning broadcast.
- `clk` in 1: sole clock; all state updates on rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `pndng` in `DRVS`: per-source FIFO not-empty.
- `D_pop` in `DRVS`×`width`: per-source FIFO head word, valid while `pndng`; first-word-fall-through.
- `pop` out `DRVS`: per-source pop strobe; one-hot or zero.
- `push` out `DRVS`: per-destination push strobe.
- `D_push` out `DRVS`×`width`: per-destination write data; all lanes carry the same word.
- `busy` out 1: FSM not in IDLE.
- `grant_id` out `$clog2(DRVS)`: index of the current or last granted source.
- `drop_cnt` out 8: saturating count of dropped packets.

## Operation
- FSM has three states: IDLE, POP, XFER.
  - IDLE → POP when `|pndng`.
  - POP → XFER unconditionally.
  - XFER → IDLE unconditionally.
- Grant selection in IDLE: the first set `pndng` bit searching upward from `last_grant+1`, wrapping modulo `DRVS`.
  - `last_grant` updates on the IDLE→POP edge.
  - A source cannot be granted twice in a row while another source is pending.
- POP:
  - `pop[g]` = 1 for exactly this cycle.
  - `D_pop[g]` is captured into `pkt` on the POP→XFER edge.
- XFER:
  - `D_push[*]` = `pkt`.
  - `dest` = `pkt[width-1 -: ID_W]`.
  - If `dest` == `BCAST`: `push[i]` = 1 for all i ≠ g.
  - If `dest` < `DRVS`: `push[dest]` = 1. Self-addressed packets (`dest` == g) are delivered back to g.
  - Otherwise: no push; `drop_cnt` increments and saturates at 255.
- `pndng[g]` falling between IDLE and POP does not cancel the grant. The pop is still issued and `pkt` captures `D_pop[g]` as presented. Sources must hold `pndng` until popped.
- Destination full is not visible to this block. Pushes are unconditional; overflow is the FIFO's concern.

## Timing
- `pop`, `push`, `D_push`, `busy`, and `grant_id` are registered. No combinational path from inputs to outputs.
- Latency:
  - `pndng` sampled high in IDLE at edge n.
  - `pop` is high during cycle n+1.
  - `push` is high during cycle n+2.
  - IDLE is reached at edge n+3.
- Throughput: one packet per 3 cycles under continuous load.
- Reset values, async on `reset`=0:
  - State IDLE; `pop`, `push`, `D_push`, `pkt` = 0.
  - `busy` = 0; `drop_cnt` = 0.
  - `grant_id` = 0, with internal `last_grant` = `DRVS-1`, so the first grant goes to driver 0.
- Reset asserted in POP or XFER aborts the packet: no push occurs, and the popped word is lost.
- Reset deassertion is synchronized by the environment. The first arbitration happens on the first rising edge with `reset`=1.

## Structure
- Package `bus_arb_pkg`:
  - `state_t` enum {IDLE, POP, XFER}.
  - Default `BCAST` and `ID_W` constants.
  - `function automatic dest_of(pkt)`.
- Sub-module `rr_picker`, parameter `N`.
  - Inputs: `req[N]`, `last[$clog2(N)]`.
  - Outputs: `gnt_idx`, `gnt_valid`.
  - Purely combinational; double-width mask-and-priority search.
- Top module holds the FSM, `pkt` register, push decode, and `drop_cnt`.

## Test plan
- Single source: `pndng`=8'h04 with `D_pop[2]`=16'h05AB → `pop`=8'h04 for one cycle, then `push`=8'h20 with `D_push`=16'h05AB; `grant_id`=2.
- Fairness: `pndng`=8'hFF held, every FIFO non-empty → grant order 0,1,…,7,0; exactly one `pop` per 3 cycles.
- Broadcast: source 3 sends 16'hFF12 → `push`=8'hF7 for one cycle, all lanes 16'hFF12.
- Invalid dest: source 1 sends 16'h0A00 with `DRVS`=8 → no push; `drop_cnt` 0→1. After 300 such packets, `drop_cnt`=255.
- Reset mid-op: `reset`=0 during the POP cycle → `pop`, `push`, and `busy` go to 0 immediately. After release with `pndng`=8'h80, the first `pop`=8'h80 arrives after one IDLE cycle.
- Self-address: source 5 sends 16'h0577 → `push`=8'h20.
